pc_gen: RTL and testbench
=========================

// Module: pc_gen
// PURPOSE
//  Upstream neighbour of the IF/ID register: owns the architectural fetch PC and drives in_pc / pc_b_j.
//  Advances PC by 4 on each fetch handshake. Accepts branch/jump and trap redirects, with trap above branch.
//  Buffers one redirect that arrives while IF is busy or the pipe is stalled, then applies it at the next handshake.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC value loaded on reset
//  PC_W       32             PC width in bits
// PORTS
//  clk           in   1     clock
//  rst           in   1     reset, asynchronous, active-low
//  fetch_ready   in   1     IF/ID can accept a new PC (its out_ready)
//  stall         in   1     global pipeline freeze
//  bj_valid      in   1     branch/jump resolved taken this cycle
//  bj_target     in   PC_W  branch/jump target
//  trap_valid    in   1     exception / xret redirect this cycle
//  trap_target   in   PC_W  trap/return target (mtvec/mepc)
//  pc            out  PC_W  current fetch PC (to in_pc)
//  pc_valid      out  1     pc is meaningful
//  redirect      out  1     pc holds a not-yet-accepted redirect target (to pc_b_j)
//  misalign      out  1     1-cycle pulse: applied target had bits[1:0]!=0
//  fetch_cnt     out  32    count of accepted fetch handshakes
// BEHAVIOUR
//  - Reset (rst=0, async): state=BOOT, pc=RESET_PC, pc_valid=0, redirect=0, misalign=0, fetch_cnt=0, pending cleared.
//  - Handshake: fire = pc_valid & fetch_ready & ~stall.
//  - States: BOOT -> RUN after exactly 1 cycle after reset release. pc_valid=1 in RUN only.
//  - Redirect source for cycle: trap_valid ? trap_target : bj_valid ? bj_target : none (trap wins ties).
//  - Pending register {pend_v, pend_trap, pend_tgt}:
//      captured when a source is present and fire=0, or when state=BOOT;
//      a trap overwrites any pending; a branch overwrites only a pending branch, never a pending trap.
//  - PC update at posedge, in RUN:
//      source present & fire       -> pc<=source target; redirect<=1; pending cleared
//      pend_v & fire & no source   -> pc<=pend_tgt; redirect<=1; pending cleared
//      fire otherwise              -> pc<=pc+4 (wraps mod 2^PC_W); redirect<=0
//      no fire                     -> pc, redirect hold; pending captures any source
//  - A source or pending redirect is applied at a fire edge even if redirect=1 from a prior redirect. The newest target wins.
//  - Each redirect target is stored with bits[1:0] forced to 0. misalign=1 in the cycle after that store iff the raw target had bits[1:0]!=0.
//  - fetch_cnt += 1 on every fire, wraps at 2^32. It is not cleared by redirects.
//  - Latency: redirect input -> pc shows target next cycle (if fire) or one cycle after the first later fire.
//  - stall=1 freezes pc, redirect, fetch_cnt. Pending still captures.
//  - Reset mid-operation discards pending and any in-progress redirect. No residual misalign pulse.
// STRUCTURE
//  - Shared package: RESET_PC default, PC_W, state enum {BOOT,RUN}, PC_INC=4.
//  - One natural sub-module: pc_redirect_buf (pending register + priority/overwrite logic).
//  - Remainder: state FF, pc/redirect FFs, fetch counter.
// TESTING
//  1 Reset release, fetch_ready=1, stall=0 -> pc=8000_0000 (valid) on the cycle after BOOT, then 8000_0004, then 8000_0008; fetch_cnt=1,2,3.
//  2 bj_valid=1, bj_target=8000_0100 with fire -> next cycle pc=8000_0100, redirect=1; following fire -> pc=8000_0104, redirect=0.
//  3 trap_valid and bj_valid in the same cycle (targets 8000_0200 / 8000_0100) -> pc=8000_0200.
//  4 fetch_ready=0; bj to 8000_0300; then trap to 8000_0400; then bj to 8000_0500; then fetch_ready=1 -> pc=8000_0400 (pending trap kept).
//  5 stall=1 for 5 cycles with bj to 8000_0600 in cycle 2 -> pc and fetch_cnt frozen; after stall drops, first fire -> pc=8000_0600.
//  6 bj_target=8000_0702 -> pc=8000_0700 and misalign pulses 1 cycle. Assert rst=0 while pend_v=1 -> pending dropped; after release pc=RESET_PC.

Source files
------------

// File: rtl/pc_gen_pkg.sv
// Shared constants and state encoding for the fetch PC generator.
package pc_gen_pkg;

  localparam int unsigned PC_W_DEFAULT     = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int unsigned PC_INC           = 4;
  localparam int unsigned CNT_W            = 32;

  typedef enum logic {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_redirect_buf.sv
// Redirect source selection (trap over branch) and the one-entry pending redirect buffer.
module pc_redirect_buf
  import pc_gen_pkg::*;
#(
  parameter int unsigned PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fire,
  input  logic            bj_valid,
  input  logic [PC_W-1:0] bj_target,
  input  logic            trap_valid,
  input  logic [PC_W-1:0] trap_target,
  output logic            apply_c,
  output logic [PC_W-1:0] apply_tgt_c,
  output logic            misalign
);

  logic            pend_v, pend_v_d;
  logic            pend_trap, pend_trap_d;
  logic [PC_W-1:0] pend_tgt, pend_tgt_d;
  logic            misalign_d;
  logic            src_v;
  logic [PC_W-1:0] src_raw;
  logic [PC_W-1:0] src_tgt;
  logic            keep_trap;
  logic            store;

  // A pending trap may only be displaced by a newer trap or consumed at a fire.
  always_comb begin
    src_v       = trap_valid | bj_valid;
    src_raw     = trap_valid ? trap_target : bj_target;
    src_tgt     = {src_raw[PC_W-1:2], 2'b00};
    keep_trap   = pend_v & pend_trap & ~trap_valid;
    store       = src_v & (fire | ~keep_trap);
    apply_c     = fire & (src_v | pend_v);
    apply_tgt_c = src_v ? src_tgt : pend_tgt;
    misalign_d  = store & (src_raw[1:0] != 2'b00);

    pend_v_d    = pend_v;
    pend_trap_d = pend_trap;
    pend_tgt_d  = pend_tgt;
    if (fire) begin
      pend_v_d    = 1'b0;
      pend_trap_d = 1'b0;
    end else if (src_v && !keep_trap) begin
      pend_v_d    = 1'b1;
      pend_trap_d = trap_valid;
      pend_tgt_d  = src_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_v    <= 1'b0;
      pend_trap <= 1'b0;
      pend_tgt  <= '0;
      misalign  <= 1'b0;
    end else begin
      pend_v    <= pend_v_d;
      pend_trap <= pend_trap_d;
      pend_tgt  <= pend_tgt_d;
      misalign  <= misalign_d;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Architectural fetch PC owner: sequential advance, trap/branch redirects, fetch handshake counter.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned      PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0]  RESET_PC = PC_W'(RESET_PC_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_ready,
  input  logic             stall,
  input  logic             bj_valid,
  input  logic [PC_W-1:0]  bj_target,
  input  logic             trap_valid,
  input  logic [PC_W-1:0]  trap_target,
  output logic [PC_W-1:0]  pc,
  output logic             pc_valid,
  output logic             redirect,
  output logic             misalign,
  output logic [CNT_W-1:0] fetch_cnt
);

  pc_state_e        state, state_d;
  logic [PC_W-1:0]  pc_d;
  logic             pc_valid_d;
  logic             redirect_d;
  logic [CNT_W-1:0] fetch_cnt_d;
  logic             fire_c;
  logic             apply_c;
  logic [PC_W-1:0]  apply_tgt_c;

  assign fire_c = pc_valid & fetch_ready & ~stall;

  pc_redirect_buf #(.PC_W(PC_W)) u_redirect_buf (
    .clk         (clk),
    .rst         (rst),
    .fire        (fire_c),
    .bj_valid    (bj_valid),
    .bj_target   (bj_target),
    .trap_valid  (trap_valid),
    .trap_target (trap_target),
    .apply_c     (apply_c),
    .apply_tgt_c (apply_tgt_c),
    .misalign    (misalign)
  );

  // BOOT lasts exactly one cycle; everything else only moves on a fire.
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    redirect_d  = redirect;
    fetch_cnt_d = fetch_cnt;
    case (state)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_BOOT;
    endcase
    pc_valid_d = (state_d == ST_RUN);
    if (fire_c) begin
      fetch_cnt_d = fetch_cnt + CNT_W'(1);
      if (apply_c) begin
        pc_d       = apply_tgt_c;
        redirect_d = 1'b1;
      end else begin
        pc_d       = pc + PC_W'(PC_INC);
        redirect_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_BOOT;
      pc        <= RESET_PC;
      pc_valid  <= 1'b0;
      redirect  <= 1'b0;
      fetch_cnt <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      pc_valid  <= pc_valid_d;
      redirect  <= redirect_d;
      fetch_cnt <= fetch_cnt_d;
    end
  end

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequential fetch, redirects, pending buffer, stall, misalign and reset.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_ready;
  logic        stall;
  logic        bj_valid;
  logic [31:0] bj_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic [31:0] pc;
  logic        pc_valid;
  logic        redirect;
  logic        misalign;
  logic [31:0] fetch_cnt;

  int checks = 0;
  int failures = 0;

  pc_gen dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_ready (fetch_ready),
    .stall       (stall),
    .bj_valid    (bj_valid),
    .bj_target   (bj_target),
    .trap_valid  (trap_valid),
    .trap_target (trap_target),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .redirect    (redirect),
    .misalign    (misalign),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    bj_valid = 1'b0; bj_target = '0; trap_valid = 1'b0; trap_target = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; fetch_ready = 1'b1; stall = 1'b0; clear_src();
    step(); step();
    checks++; if (pc !== 32'h8000_0000) begin failures++; $display("FAIL rst_pc got=%h exp=%h", pc, 32'h8000_0000); end
    checks++; if (pc_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", pc_valid); end
    checks++; if (redirect !== 1'b0 || misalign !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b exp=00", redirect, misalign); end
    checks++; if (fetch_cnt !== 32'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", fetch_cnt); end
    rst = 1'b1;
    step();
    checks++; if (pc_valid !== 1'b1 || pc !== 32'h8000_0000) begin failures++; $display("FAIL boot_run got=%b/%h exp=1/80000000", pc_valid, pc); end
    checks++; if (fetch_cnt !== 32'd0) begin failures++; $display("FAIL boot_cnt got=%0d exp=0", fetch_cnt); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'h8000_0004; exp_pc[1] = 32'h8000_0008; exp_pc[2] = 32'h8000_000C;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (pc !== exp_pc[i] || redirect !== 1'b0) begin failures++; $display("FAIL seq_pc%0d got=%h/%b exp=%h/0", i, pc, redirect, exp_pc[i]); end
      checks++; if (fetch_cnt !== 32'(i + 1)) begin failures++; $display("FAIL seq_cnt%0d got=%0d exp=%0d", i, fetch_cnt, i + 1); end
    end
  endtask

  task automatic test_branch();
    bj_valid = 1'b1; bj_target = 32'h8000_0100;
    step(); clear_src();
    checks++; if (pc !== 32'h8000_0100 || redirect !== 1'b1) begin failures++; $display("FAIL bj_pc got=%h/%b exp=80000100/1", pc, redirect); end
    checks++; if (fetch_cnt !== 32'd4) begin failures++; $display("FAIL bj_cnt got=%0d exp=4", fetch_cnt); end
    step();
    checks++; if (pc !== 32'h8000_0104 || redirect !== 1'b0) begin failures++; $display("FAIL bj_next got=%h/%b exp=80000104/0", pc, redirect); end
  endtask

  task automatic test_tie();
    trap_valid = 1'b1; trap_target = 32'h8000_0200; bj_valid = 1'b1; bj_target = 32'h8000_0100;
    step(); clear_src();
    checks++; if (pc !== 32'h8000_0200 || redirect !== 1'b1) begin failures++; $display("FAIL tie_pc got=%h/%b exp=80000200/1", pc, redirect); end
    step();
    checks++; if (pc !== 32'h8000_0204 || fetch_cnt !== 32'd7) begin failures++; $display("FAIL tie_next got=%h/%0d exp=80000204/7", pc, fetch_cnt); end
  endtask

  task automatic test_pending_priority();
    fetch_ready = 1'b0;
    bj_valid = 1'b1; bj_target = 32'h8000_0300;
    step(); clear_src();
    checks++; if (pc !== 32'h8000_0204 || fetch_cnt !== 32'd7) begin failures++; $display("FAIL pend_hold got=%h/%0d exp=80000204/7", pc, fetch_cnt); end
    trap_valid = 1'b1; trap_target = 32'h8000_0400;
    step(); clear_src();
    bj_valid = 1'b1; bj_target = 32'h8000_0500;
    step(); clear_src();
    checks++; if (pc !== 32'h8000_0204 || redirect !== 1'b0) begin failures++; $display("FAIL pend_hold2 got=%h/%b exp=80000204/0", pc, redirect); end
    fetch_ready = 1'b1;
    step();
    checks++; if (pc !== 32'h8000_0400 || redirect !== 1'b1) begin failures++; $display("FAIL pend_trap got=%h/%b exp=80000400/1", pc, redirect); end
    checks++; if (fetch_cnt !== 32'd8) begin failures++; $display("FAIL pend_cnt got=%0d exp=8", fetch_cnt); end
    step();
    checks++; if (pc !== 32'h8000_0404 || redirect !== 1'b0) begin failures++; $display("FAIL pend_clear got=%h/%b exp=80000404/0", pc, redirect); end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin bj_valid = 1'b1; bj_target = 32'h8000_0600; end
      step(); clear_src();
      checks++; if (pc !== 32'h8000_0404 || fetch_cnt !== 32'd9) begin failures++; $display("FAIL stall_frz%0d got=%h/%0d exp=80000404/9", i, pc, fetch_cnt); end
    end
    stall = 1'b0;
    step();
    checks++; if (pc !== 32'h8000_0600 || redirect !== 1'b1) begin failures++; $display("FAIL stall_apply got=%h/%b exp=80000600/1", pc, redirect); end
    checks++; if (fetch_cnt !== 32'd10) begin failures++; $display("FAIL stall_cnt got=%0d exp=10", fetch_cnt); end
    step();
    checks++; if (pc !== 32'h8000_0604 || fetch_cnt !== 32'd11) begin failures++; $display("FAIL stall_next got=%h/%0d exp=80000604/11", pc, fetch_cnt); end
  endtask

  task automatic test_back_to_back();
    bj_valid = 1'b1; bj_target = 32'hFFFF_FFFC;
    step();
    checks++; if (pc !== 32'hFFFF_FFFC || redirect !== 1'b1) begin failures++; $display("FAIL b2b_first got=%h/%b exp=fffffffc/1", pc, redirect); end
    bj_target = 32'h0000_1000;
    step(); clear_src();
    checks++; if (pc !== 32'h0000_1000 || redirect !== 1'b1) begin failures++; $display("FAIL b2b_second got=%h/%b exp=00001000/1", pc, redirect); end
    step();
    checks++; if (pc !== 32'h0000_1004 || fetch_cnt !== 32'd14) begin failures++; $display("FAIL b2b_next got=%h/%0d exp=00001004/14", pc, fetch_cnt); end
  endtask

  task automatic test_wrap();
    bj_valid = 1'b1; bj_target = 32'hFFFF_FFFC;
    step(); clear_src();
    step();
    checks++; if (pc !== 32'h0000_0000 || redirect !== 1'b0) begin failures++; $display("FAIL wrap_pc got=%h/%b exp=00000000/0", pc, redirect); end
    checks++; if (fetch_cnt !== 32'd16) begin failures++; $display("FAIL wrap_cnt got=%0d exp=16", fetch_cnt); end
  endtask

  task automatic test_misalign();
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL mis_idle got=%b exp=0", misalign); end
    bj_valid = 1'b1; bj_target = 32'h8000_0702;
    step(); clear_src();
    checks++; if (pc !== 32'h8000_0700 || redirect !== 1'b1) begin failures++; $display("FAIL mis_pc got=%h/%b exp=80000700/1", pc, redirect); end
    checks++; if (misalign !== 1'b1) begin failures++; $display("FAIL mis_pulse got=%b exp=1", misalign); end
    step();
    checks++; if (misalign !== 1'b0 || pc !== 32'h8000_0704) begin failures++; $display("FAIL mis_end got=%b/%h exp=0/80000704", misalign, pc); end
  endtask

  task automatic test_reset_pending();
    fetch_ready = 1'b0;
    bj_valid = 1'b1; bj_target = 32'h8000_0803;
    step(); clear_src();
    checks++; if (pc !== 32'h8000_0704 || misalign !== 1'b1) begin failures++; $display("FAIL rp_capture got=%h/%b exp=80000704/1", pc, misalign); end
    rst = 1'b0;
    #1;
    checks++; if (pc !== 32'h8000_0000 || pc_valid !== 1'b0 || fetch_cnt !== 32'd0) begin failures++; $display("FAIL rp_async got=%h/%b/%0d exp=80000000/0/0", pc, pc_valid, fetch_cnt); end
    checks++; if (misalign !== 1'b0 || redirect !== 1'b0) begin failures++; $display("FAIL rp_flags got=%b%b exp=00", misalign, redirect); end
    step(); step();
    rst = 1'b1; fetch_ready = 1'b1;
    step();
    checks++; if (pc !== 32'h8000_0000 || pc_valid !== 1'b1 || misalign !== 1'b0) begin failures++; $display("FAIL rp_boot got=%h/%b/%b exp=80000000/1/0", pc, pc_valid, misalign); end
    step();
    checks++; if (pc !== 32'h8000_0004 || redirect !== 1'b0) begin failures++; $display("FAIL rp_drop got=%h/%b exp=80000004/0", pc, redirect); end
    checks++; if (fetch_cnt !== 32'd1) begin failures++; $display("FAIL rp_cnt got=%0d exp=1", fetch_cnt); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_tie();
    test_pending_priority();
    test_stall();
    test_back_to_back();
    test_wrap();
    test_misalign();
    test_reset_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
